sum_entry_controller: RTL and testbench

//  Sequences the keypad-to-adder path for the two-operand decimal calculator.
//  - Accumulates keypad digits into two binary operands (number1, number2).
//  - Fires a one-cycle start_suma to the adder and waits for its valid.
//  - Latches and holds the sum for the display stage.
//  - Sits between the keypad scanner/debouncer and adder_submodule.

---
 rtl/sum_entry_if.sv | 31 +++
 rtl/sum_entry_controller.sv | 139 +++++++++++++
 tb/tb_sum_entry_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sum_entry_if.sv
// sum_entry_if: keypad, adder and display signals of sum_entry_controller.
// The master modport is the controller's view; slave is the surrounding logic.
interface sum_entry_if #(
    parameter int NUM_W = 12,
    parameter int SUM_W = 14,
    parameter int DC_W  = 2
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic [NUM_W-1:0] number1;
    logic [NUM_W-1:0] number2;
    logic             start_suma;
    logic [SUM_W-1:0] result;
    logic             result_valid;
    logic             operand_sel;
    logic [DC_W-1:0]  digit_count;
    logic             busy;
    logic             err;
    modport master (
        input  key_valid, key_code, sum_in, sum_valid,
        output number1, number2, start_suma, result, result_valid,
               operand_sel, digit_count, busy, err
    );
    modport slave (
        output key_valid, key_code, sum_in, sum_valid,
        input  number1, number2, start_suma, result, result_valid,
               operand_sel, digit_count, busy, err
    );
endinterface

// File: rtl/sum_entry_controller.sv
// sum_entry_controller: keypad digit entry into two operands, adder handshake, sum hold.
// Defining SUM_WATCHDOG_EN adds a WAIT timeout that pulses err and clears.
module sum_entry_controller #(
    parameter int NUM_DIGITS = 3,
    parameter int NUM_W      = 12,
    parameter int SUM_W      = 14,
    parameter int WAIT_LIMIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    sum_entry_if.master  io
);
    localparam int DC_W = $clog2(NUM_DIGITS + 1);

    typedef enum logic [2:0] {ENTER_A, ENTER_B, START, WAIT, SHOW} state_t;

    state_t           state_q, state_d;
    logic [NUM_W-1:0] n1_q, n1_d, n2_q, n2_d;
    logic [DC_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0] res_q, res_d;
    logic             rv_q, rv_d;
    logic             is_dig, is_plus, is_eq, is_clr, can_dig, timeout;
    logic [NUM_W-1:0] dig;

    assign is_dig  = io.key_valid && io.key_code <= 4'd9;
    assign is_plus = io.key_valid && io.key_code == 4'hA;
    assign is_eq   = io.key_valid && io.key_code == 4'hB;
    assign is_clr  = io.key_valid && io.key_code == 4'hC;
    assign can_dig = is_dig && cnt_q < DC_W'(NUM_DIGITS);
    assign dig     = NUM_W'(io.key_code);

`ifdef SUM_WATCHDOG_EN
    localparam int WD_W = $clog2(WAIT_LIMIT + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    assign timeout = state_q == WAIT && !io.sum_valid && wd_q == WD_W'(WAIT_LIMIT - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (state_q == WAIT) ? wd_q + 1'b1 : '0;
            err_q <= timeout;
        end
    end
    assign io.err = err_q;
`else
    assign timeout = 1'b0;
    assign io.err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rv_d    = rv_q;
        case (state_q)
            ENTER_A: begin
                if (can_dig) begin
                    n1_d  = n1_q * NUM_W'(10) + dig;
                    cnt_d = cnt_q + 1'b1;
                end else if (is_plus) begin
                    state_d = ENTER_B;
                    cnt_d   = '0;
                    n2_d    = '0;
                end
            end
            ENTER_B: begin
                if (can_dig) begin
                    n2_d  = n2_q * NUM_W'(10) + dig;
                    cnt_d = cnt_q + 1'b1;
                end else if (is_eq) begin
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (io.sum_valid) begin
                    res_d   = io.sum_in;
                    rv_d    = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (is_dig) begin
                    n1_d    = dig;
                    n2_d    = '0;
                    cnt_d   = DC_W'(1);
                    rv_d    = 1'b0;
                    state_d = ENTER_A;
                end else if (is_plus) begin
                    // Chaining keeps only the low operand-width bits of the sum
                    n1_d    = res_q[NUM_W-1:0];
                    n2_d    = '0;
                    cnt_d   = '0;
                    rv_d    = 1'b0;
                    state_d = ENTER_B;
                end
            end
            default: state_d = ENTER_A;
        endcase
        if (is_clr || timeout) begin
            n1_d    = '0;
            n2_d    = '0;
            cnt_d   = '0;
            rv_d    = 1'b0;
            state_d = ENTER_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ENTER_A;
            n1_q    <= '0;
            n2_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
        end
    end

    assign io.number1      = n1_q;
    assign io.number2      = n2_q;
    assign io.result       = res_q;
    assign io.result_valid = rv_q;
    assign io.digit_count  = cnt_q;
    assign io.operand_sel  = state_q == ENTER_B;
    assign io.start_suma   = state_q == START;
    assign io.busy         = state_q == START || state_q == WAIT;
endmodule

// File: tb/tb_sum_entry_controller.sv
// tb_sum_entry_controller: directed keypad sequences with a stub adder and result scoreboard.
module tb_sum_entry_controller;
    localparam int NUM_DIGITS = 3;
    localparam int NUM_W      = 12;
    localparam int SUM_W      = 14;
    localparam int WAIT_LIMIT = 16;
    localparam int DC_W       = $clog2(NUM_DIGITS + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   op_q[$];
    int   exp_q[$];

    sum_entry_if #(.NUM_W(NUM_W), .SUM_W(SUM_W), .DC_W(DC_W)) io ();

    sum_entry_controller #(
        .NUM_DIGITS(NUM_DIGITS), .NUM_W(NUM_W), .SUM_W(SUM_W), .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(io.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        io.key_valid = 1'b1;
        io.key_code  = k;
        tick();
        io.key_valid = 1'b0;
        io.key_code  = 4'h0;
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            key(c == "+" ? 4'hA : c == "=" ? 4'hB : c == "C" ? 4'hC : 4'(c - 8'd48));
        end
    endtask

    // Press '=', check the start pulse and operands, answer as the adder, check the held sum
    task automatic calc(input int a, input int b);
        op_q.push_back(a);
        op_q.push_back(b);
        exp_q.push_back(a + b);
        key(4'hB);
        chk("start_suma", 32'(io.start_suma), 1);
        chk("busy_start", 32'(io.busy), 1);
        chk("number1", 32'(io.number1), op_q.pop_front());
        chk("number2", 32'(io.number2), op_q.pop_front());
        tick();
        chk("start_suma_end", 32'(io.start_suma), 0);
        chk("rv_in_wait", 32'(io.result_valid), 0);
        io.sum_valid = 1'b1;
        io.sum_in    = SUM_W'(io.number1) + SUM_W'(io.number2);
        tick();
        io.sum_valid = 1'b0;
        chk("result_valid", 32'(io.result_valid), 1);
        chk("result", 32'(io.result), exp_q.pop_front());
        chk("busy_show", 32'(io.busy), 0);
    endtask

    initial begin
        io.key_valid = 1'b0;
        io.key_code  = 4'h0;
        io.sum_in    = '0;
        io.sum_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_number1", 32'(io.number1), 0);
        chk("rst_number2", 32'(io.number2), 0);
        chk("rst_result", 32'(io.result), 0);
        chk("rst_rv", 32'(io.result_valid), 0);
        chk("rst_start", 32'(io.start_suma), 0);
        chk("rst_opsel", 32'(io.operand_sel), 0);
        chk("rst_dcount", 32'(io.digit_count), 0);
        chk("rst_busy", 32'(io.busy), 0);
        chk("rst_err", 32'(io.err), 0);

        keys("123");
        chk("a_dcount", 32'(io.digit_count), 3);
        chk("a_number1", 32'(io.number1), 123);
        chk("a_opsel", 32'(io.operand_sel), 0);
        keys("+");
        chk("b_opsel", 32'(io.operand_sel), 1);
        chk("b_dcount", 32'(io.digit_count), 0);
        keys("456+");
        chk("b_plus_ignored", 32'(io.operand_sel), 1);
        chk("b_number2", 32'(io.number2), 456);
        calc(123, 456);

        keys("+1");
        calc(579, 1);
        keys("5");
        chk("show_dig_rv", 32'(io.result_valid), 0);
        chk("show_dig_n1", 32'(io.number1), 5);
        chk("show_dig_n2", 32'(io.number2), 0);
        chk("show_dig_opsel", 32'(io.operand_sel), 0);
        chk("show_dig_dcount", 32'(io.digit_count), 1);

        keys("C9999");
        chk("max_dcount", 32'(io.digit_count), 3);
        chk("max_number1", 32'(io.number1), 999);
        keys("+999");
        calc(999, 999);
        io.sum_valid = 1'b1;
        io.sum_in    = SUM_W'(1234);
        tick();
        io.sum_valid = 1'b0;
        chk("stray_sum_valid", 32'(io.result), 1998);
        keys("=");
        chk("show_eq_busy", 32'(io.busy), 0);
        chk("show_eq_rv", 32'(io.result_valid), 1);

        keys("+999");
        calc(1998, 999);
        keys("+999");
        calc(2997, 999);
        keys("+999");
        calc(3996, 999);
        keys("+");
        chk("chain_dcount", 32'(io.digit_count), 0);
        calc(899, 0);

        keys("C=");
        chk("a_eq_busy", 32'(io.busy), 0);
        chk("a_eq_opsel", 32'(io.operand_sel), 0);
        keys("+7");
        calc(0, 7);

        keys("C1+2=");
        tick();
        chk("wait_busy", 32'(io.busy), 1);
        keys("C");
        chk("clr_busy", 32'(io.busy), 0);
        chk("clr_rv", 32'(io.result_valid), 0);
        chk("clr_number1", 32'(io.number1), 0);
        chk("clr_opsel", 32'(io.operand_sel), 0);
        io.sum_valid = 1'b1;
        io.sum_in    = SUM_W'(3);
        tick();
        io.sum_valid = 1'b0;
        chk("late_sum_rv", 32'(io.result_valid), 0);
        chk("late_sum_busy", 32'(io.busy), 0);

        keys("12+3");
        reset = 1'b1;
        #1;
        chk("arst_number1", 32'(io.number1), 0);
        chk("arst_number2", 32'(io.number2), 0);
        chk("arst_dcount", 32'(io.digit_count), 0);
        chk("arst_opsel", 32'(io.operand_sel), 0);
        chk("arst_result", 32'(io.result), 0);
        #1;
        reset = 1'b0;
        tick();
        keys("4+5");
        calc(4, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
